// File: rtl/fec_cc_encoder.sv
// Rate-1/2 tail-biting convolutional encoder (K=7) with a ping-pong input store.
// One bank fills from the randomizer while the other is encoded, emitting X then Y for each bit.
`timescale 1ns/1ps
module fec_cc_encoder #(
   parameter int         BLOCK_BITS = 96,
   parameter logic [6:0] G1         = 7'o171,
   parameter logic [6:0] G2         = 7'o133
) (
   input  logic clk,
   input  logic resetN,
   input  logic data_in,
   input  logic valid_in,
   output logic ready_fec,
   output logic data_out,
   output logic valid_out,
   input  logic ready_interleaver
);

   localparam int            CW   = $clog2(BLOCK_BITS);
   localparam logic [CW-1:0] LAST = CW'(BLOCK_BITS - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_ENC} state_t;

   state_t                      state_q, state_d;
   logic [1:0][BLOCK_BITS-1:0]  mem_q, mem_d;
   logic [1:0]                  full_q, full_d;
   logic                        wr_bank_q, wr_bank_d;
   logic                        rd_bank_q, rd_bank_d;
   logic [CW-1:0]               wr_cnt_q, wr_cnt_d;
   logic [CW-1:0]               idx_q, idx_d;
   logic                        phase_q, phase_d;
   logic [5:0]                  s_q, s_d;
   logic                        ready_fec_q, ready_fec_d;
   logic                        data_out_q, data_out_d;
   logic                        valid_out_q, valid_out_d;

   logic                        wr_fire, wr_last;
   logic [1:0]                  full_now;
   logic [CW-1:0]               idx_nx;
   logic [5:0]                  s_load, s_shift;
   logic                        u_cur, u_next, u_first;

   // {u, s1..s6} with u at bit 6 lines up with the generator MSB tapping the input bit.
   function automatic logic enc_bit(input logic [6:0] g, input logic u, input logic [5:0] s);
      return ^(g & {u, s});
   endfunction

   always_comb begin
      state_d     = state_q;
      mem_d       = mem_q;
      full_d      = full_q;
      wr_bank_d   = wr_bank_q;
      rd_bank_d   = rd_bank_q;
      wr_cnt_d    = wr_cnt_q;
      idx_d       = idx_q;
      phase_d     = phase_q;
      s_d         = s_q;
      data_out_d  = data_out_q;
      valid_out_d = valid_out_q;

      wr_fire = valid_in & ready_fec_q;
      wr_last = wr_fire & (wr_cnt_q == LAST);
      if (wr_fire) begin
         mem_d[wr_bank_q][wr_cnt_q] = data_in;
         wr_cnt_d = wr_last ? '0 : wr_cnt_q + 1'b1;
      end
      if (wr_last) begin
         full_d[wr_bank_q] = 1'b1;
         wr_bank_d         = ~wr_bank_q;
      end

      // A bank completing this cycle counts as full so encoding can start one cycle earlier.
      full_now = full_q;
      if (wr_last) full_now[wr_bank_q] = 1'b1;

      s_load  = mem_q[rd_bank_q][BLOCK_BITS-1 -: 6];
      u_first = mem_q[rd_bank_q][0];
      u_cur   = mem_q[rd_bank_q][idx_q];
      idx_nx  = idx_q + 1'b1;
      u_next  = mem_q[rd_bank_q][idx_nx];
      s_shift = {u_cur, s_q[5:1]};

      case (state_q)
         ST_IDLE: begin
            if (full_now[rd_bank_q]) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            s_d         = s_load;
            idx_d       = '0;
            phase_d     = 1'b0;
            data_out_d  = enc_bit(G1, u_first, s_load);
            valid_out_d = 1'b1;
            state_d     = ST_ENC;
         end
         ST_ENC: begin
            if (valid_out_q & ready_interleaver) begin
               if (!phase_q) begin
                  phase_d    = 1'b1;
                  data_out_d = enc_bit(G2, u_cur, s_q);
               end else begin
                  phase_d = 1'b0;
                  s_d     = s_shift;
                  idx_d   = idx_nx;
                  if (idx_q == LAST) begin
                     full_d[rd_bank_q] = 1'b0;
                     rd_bank_d         = ~rd_bank_q;
                     idx_d             = '0;
                     valid_out_d       = 1'b0;
                     data_out_d        = 1'b0;
                     state_d           = full_now[~rd_bank_q] ? ST_LOAD : ST_IDLE;
                  end else begin
                     data_out_d = enc_bit(G1, u_next, s_shift);
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      ready_fec_d = ~full_d[wr_bank_d];
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         state_q     <= ST_IDLE;
         full_q      <= '0;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         wr_cnt_q    <= '0;
         idx_q       <= '0;
         phase_q     <= 1'b0;
         s_q         <= '0;
         ready_fec_q <= 1'b0;
         data_out_q  <= 1'b0;
         valid_out_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         full_q      <= full_d;
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         wr_cnt_q    <= wr_cnt_d;
         idx_q       <= idx_d;
         phase_q     <= phase_d;
         s_q         <= s_d;
         ready_fec_q <= ready_fec_d;
         data_out_q  <= data_out_d;
         valid_out_q <= valid_out_d;
      end
   end

   // Bank contents are only read once marked full, so they need no reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign ready_fec = ready_fec_q;
   assign data_out  = data_out_q;
   assign valid_out = valid_out_q;

endmodule

// File: tb/tb_fec_cc_encoder.sv
// Directed bench for fec_cc_encoder: reference vector, back-to-back blocks, backpressure,
// tail-biting wrap and resets mid-block / mid-encode.
`timescale 1ns/1ps
module tb_fec_cc_encoder;

   localparam int N  = 96;
   localparam int CN = 2 * N;
   localparam logic [N-1:0]  STD_IN  = 96'h558AC4A53A1724E163AC2BF9;
   localparam logic [CN-1:0] STD_OUT = 192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA;

   logic clk = 1'b0;
   logic resetN = 1'b0;
   logic data_in = 1'b0;
   logic valid_in = 1'b0;
   logic ready_interleaver = 1'b1;
   logic ready_fec, data_out, valid_out;

   int tests_run = 0;
   int tests_failed = 0;
   int rdy_low_cnt = 0;
   logic got_q[$];
   logic [CN-1:0] exp_q[$];

   fec_cc_encoder #(.BLOCK_BITS(N)) dut (
      .clk(clk), .resetN(resetN), .data_in(data_in), .valid_in(valid_in),
      .ready_fec(ready_fec), .data_out(data_out), .valid_out(valid_out),
      .ready_interleaver(ready_interleaver)
   );

   always #5 clk = ~clk;

   // Record every coded bit that will transfer at the coming rising edge.
   always @(negedge clk) begin
      if (resetN && valid_out && ready_interleaver) got_q.push_back(data_out);
      if (resetN && valid_in && !ready_fec) rdy_low_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   task automatic drive_bit(input logic b);
      int w = 0;
      data_in  = b;
      valid_in = 1'b1;
      @(negedge clk);
      while (!ready_fec && w < 1000) begin
         @(negedge clk);
         w++;
      end
      if (w >= 1000) begin
         tests_run++;
         tests_failed++;
         $display("FAIL drive_bit: ready_fec stuck at %0b, required 1", ready_fec);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_block(input logic [N-1:0] v);
      for (int i = N - 1; i >= 0; i--) drive_bit(v[i]);
   endtask

   task automatic wait_out(input int n, input int budget);
      int c = 0;
      while (got_q.size() < n && c < budget) begin
         @(posedge clk);
         c++;
      end
      #1;
   endtask

   function automatic logic [CN-1:0] pop_block();
      logic [CN-1:0] v = '0;
      for (int i = 0; i < CN; i++) v = {v[CN-2:0], got_q.pop_front()};
      return v;
   endfunction

   task automatic test_reset();
      resetN   = 1'b0;
      valid_in = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (ready_fec !== 1'b0) begin tests_failed++; $display("FAIL reset_ready_fec: got %0b, required 0", ready_fec); end
      tests_run++;
      if (valid_out !== 1'b0) begin tests_failed++; $display("FAIL reset_valid_out: got %0b, required 0", valid_out); end
      tests_run++;
      if (data_out !== 1'b0) begin tests_failed++; $display("FAIL reset_data_out: got %0b, required 0", data_out); end
      @(posedge clk);
      #1;
      resetN = 1'b1;
      @(negedge clk);
      tests_run++;
      if (ready_fec !== 1'b0) begin tests_failed++; $display("FAIL release_ready_first_cycle: got %0b, required 0", ready_fec); end
      @(negedge clk);
      tests_run++;
      if (ready_fec !== 1'b1) begin tests_failed++; $display("FAIL release_ready_second_cycle: got %0b, required 1", ready_fec); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_standard();
      logic [CN-1:0] got;
      got_q.delete();
      send_block(STD_IN);
      valid_in = 1'b0;
      @(negedge clk);
      tests_run++;
      if (valid_out !== 1'b0) begin tests_failed++; $display("FAIL latency_load_cycle: valid_out %0b, required 0", valid_out); end
      @(negedge clk);
      tests_run++;
      if (valid_out !== 1'b1) begin tests_failed++; $display("FAIL latency_first_x: valid_out %0b, required 1", valid_out); end
      wait_out(CN, 600);
      tests_run++;
      if (got_q.size() != CN) begin
         tests_failed++;
         $display("FAIL standard_count: got %0d bits, required %0d", got_q.size(), CN);
      end else begin
         got = pop_block();
         tests_run++;
         if (got !== STD_OUT) begin tests_failed++; $display("FAIL standard_vector: got %h, required %h", got, STD_OUT); end
      end
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back();
      logic [CN-1:0] got;
      got_q.delete();
      exp_q.delete();
      rdy_low_cnt = 0;
      send_block(STD_IN);
      send_block(STD_IN);
      tests_run++;
      if (rdy_low_cnt != 0) begin tests_failed++; $display("FAIL b2b_early_stall: %0d stall cycles, required 0", rdy_low_cnt); end
      for (int k = 0; k < 3; k++) send_block(STD_IN);
      valid_in = 1'b0;
      for (int k = 0; k < 5; k++) exp_q.push_back(STD_OUT);
      wait_out(5 * CN, 2500);
      tests_run++;
      if (rdy_low_cnt == 0) begin tests_failed++; $display("FAIL b2b_full_stall: got %0d stall cycles, required > 0", rdy_low_cnt); end
      tests_run++;
      if (got_q.size() != 5 * CN) begin
         tests_failed++;
         $display("FAIL b2b_count: got %0d bits, required %0d", got_q.size(), 5 * CN);
      end else begin
         for (int k = 0; k < 5; k++) begin
            logic [CN-1:0] e;
            e   = exp_q.pop_front();
            got = pop_block();
            tests_run++;
            if (got !== e) begin tests_failed++; $display("FAIL b2b_block%0d: got %h, required %h", k, got, e); end
         end
      end
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic test_backpressure();
      logic [CN-1:0] got;
      got_q.delete();
      fork
         begin
            send_block(STD_IN);
            valid_in = 1'b0;
         end
         begin : bp_watch
            logic prev_stall;
            logic prev_d;
            int   c;
            prev_stall = 1'b0;
            prev_d     = 1'b0;
            c          = 0;
            while (got_q.size() < CN && c < 2000) begin
               @(negedge clk);
               if (prev_stall) begin
                  tests_run++;
                  if (data_out !== prev_d || valid_out !== 1'b1) begin
                     tests_failed++;
                     $display("FAIL stall_hold: data_out %0b valid_out %0b, required %0b and 1", data_out, valid_out, prev_d);
                  end
               end
               prev_stall = valid_out && !ready_interleaver;
               prev_d     = data_out;
               @(posedge clk);
               #1;
               ready_interleaver = 1'($urandom_range(0, 1));
               c++;
            end
         end
      join
      ready_interleaver = 1'b1;
      tests_run++;
      if (got_q.size() != CN) begin
         tests_failed++;
         $display("FAIL bp_count: got %0d bits, required %0d", got_q.size(), CN);
      end else begin
         got = pop_block();
         tests_run++;
         if (got !== STD_OUT) begin tests_failed++; $display("FAIL bp_vector: got %h, required %h", got, STD_OUT); end
      end
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic test_tail_biting();
      logic [CN-1:0] got;
      logic [CN-1:0] e;
      logic [N-1:0]  v;
      got_q.delete();
      v = '0;
      send_block(v);
      valid_in = 1'b0;
      wait_out(CN, 600);
      got = (got_q.size() == CN) ? pop_block() : {CN{1'bx}};
      tests_run++;
      if (got !== {CN{1'b0}}) begin tests_failed++; $display("FAIL all_zero: got %h, required 0", got); end
      repeat (5) @(posedge clk);
      #1;
      // Single 1 as the last bit: it seeds s1, so the G1/G2 response wraps to the block start.
      got_q.delete();
      v = 96'h1;
      e = '0;
      e[CN-1 -: 12] = 12'hBC7;
      e[1:0]        = 2'b11;
      send_block(v);
      valid_in = 1'b0;
      wait_out(CN, 600);
      got = (got_q.size() == CN) ? pop_block() : {CN{1'bx}};
      tests_run++;
      if (got !== e) begin tests_failed++; $display("FAIL tail_biting: got %h, required %h", got, e); end
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid_block();
      logic [CN-1:0] got;
      got_q.delete();
      for (int i = N - 1; i >= N - 40; i--) drive_bit(STD_IN[i]);
      valid_in = 1'b0;
      resetN   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      resetN = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if (got_q.size() != 0) begin tests_failed++; $display("FAIL partial_no_output: got %0d bits, required 0", got_q.size()); end
      send_block(STD_IN);
      valid_in = 1'b0;
      wait_out(CN, 600);
      repeat (300) @(posedge clk);
      #1;
      tests_run++;
      if (got_q.size() != CN) begin
         tests_failed++;
         $display("FAIL fresh_count: got %0d bits, required %0d", got_q.size(), CN);
      end else begin
         got = pop_block();
         tests_run++;
         if (got !== STD_OUT) begin tests_failed++; $display("FAIL fresh_vector: got %h, required %h", got, STD_OUT); end
      end
   endtask

   task automatic test_reset_mid_encode();
      int c = 0;
      int n0;
      got_q.delete();
      send_block(STD_IN);
      valid_in = 1'b0;
      while (got_q.size() < 100 && c < 600) begin
         @(posedge clk);
         c++;
      end
      #1;
      tests_run++;
      if (got_q.size() < 100) begin tests_failed++; $display("FAIL reach_100: got %0d bits, required 100", got_q.size()); end
      resetN = 1'b0;
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (valid_out !== 1'b0) begin tests_failed++; $display("FAIL enc_reset_valid: got %0b, required 0", valid_out); end
      @(posedge clk);
      #1;
      resetN = 1'b1;
      n0 = got_q.size();
      @(negedge clk);
      tests_run++;
      if (ready_fec !== 1'b0) begin tests_failed++; $display("FAIL enc_reset_ready_c0: got %0b, required 0", ready_fec); end
      @(negedge clk);
      tests_run++;
      if (ready_fec !== 1'b1) begin tests_failed++; $display("FAIL enc_reset_ready_c1: got %0b, required 1", ready_fec); end
      repeat (300) @(posedge clk);
      #1;
      tests_run++;
      if (got_q.size() != n0) begin tests_failed++; $display("FAIL enc_reset_silent: got %0d bits, required %0d", got_q.size(), n0); end
   endtask

   initial begin
      test_reset();
      test_standard();
      test_back_to_back();
      test_backpressure();
      test_tail_biting();
      test_reset_mid_block();
      test_reset_mid_encode();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
